simd_hilo_acc: RTL and testbench
================================

SIMD_HILO_ACC -- requirements
Module: simd_hilo_acc

Interface
REQ-001 Parameter SIMD8, default 2'b01, simd_sel code for four 16-bit product lanes.
REQ-002 Parameter SIMD16, default 2'b10, simd_sel code for two 32-bit product lanes; any other code selects one 64-bit lane.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  prdct/simd_sel/op are valid this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 simd_sel  input  2  lane mode of prdct, same encoding as the upstream multiplier.
REQ-008 op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-009 prdct  input  64  packed product from the SIMD multiplier.
REQ-010 hi  output  32  accumulator bits [63:32].
REQ-011 lo  output  32  accumulator bits [31:0].
REQ-012 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-013 ovf  output  4  sticky per-lane overflow/underflow flags.

Function
REQ-014 The FSM SHALL have states IDLE, OP_LO, OP_HI; IDLE->OP_LO on in_valid&&in_ready, OP_LO->OP_HI unconditionally, OP_HI->IDLE unconditionally.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid while not in IDLE SHALL be ignored with no state change.
REQ-016 On accept, prdct, simd_sel and op SHALL be captured; later input changes SHALL not affect the operation.
REQ-017 OP_LO SHALL update acc[31:0]; OP_HI SHALL update acc[63:32]; hi/lo SHALL show the full result in the cycle after OP_HI, with done=1 in that cycle (latency 3 cycles accept-to-done).
REQ-018 Lanes: SIMD8 = acc[16k+15:16k], k=0..3; SIMD16 = acc[32k+31:32k], k=0..1; 64-bit = acc[63:0] with the OP_LO carry/borrow registered and applied in OP_HI.
REQ-019 LOAD SHALL set acc=prdct; CLEAR SHALL set acc=0 and ovf=0; ADD SHALL set each lane to lane+prdct_lane; SUB SHALL set each lane to lane-prdct_lane; all unsigned, no carry between lanes except REQ-018 64-bit mode.
REQ-020 Lane carry-out (ADD) or borrow (SUB) SHALL set ovf[k] for lane k (SIMD16 uses ovf[1:0], 64-bit uses ovf[0]); ovf bits SHALL stay set until CLEAR or reset.
REQ-021 A new operation SHALL be accepted in the done cycle (back-to-back throughput one op per 3 cycles).
REQ-022 Changing simd_sel between operations SHALL reinterpret the current acc without modifying it.

Reset
REQ-023 reset SHALL force state=IDLE, acc=0, hi=lo=0, ovf=0, done=0, in_ready=1 on the next clock edge.
REQ-024 reset SHALL take priority over every other input, including in OP_LO/OP_HI, aborting the operation with no partial result retained.

Configuration
REQ-025 Macro SIMD_ACC_SAT_EN: when defined, an overflowing ADD lane SHALL clamp to all-ones and an underflowing SUB lane SHALL clamp to zero, with ovf set as in REQ-020.
REQ-026 When SIMD_ACC_SAT_EN is undefined, lanes SHALL wrap modulo 2^lane_width, with ovf set as in REQ-020.

Verification
REQ-027 Reset mid-OP_HI -> next cycle hi=lo=0, ovf=0, done=0, in_ready=1.
REQ-028 SIMD8 LOAD prdct=0x0001_0002_0003_0004 then ADD same -> hi=0x0002_0004, lo=0x0006_0008, ovf=0, done once per op 3 cycles after accept.
REQ-029 SIMD8 LOAD 0xFFFF in lane 0, ADD 0x0002 -> lane 0 = 0x0001 and ovf[0]=1 (no macro); lane 0 = 0xFFFF, ovf[0]=1 (SIMD_ACC_SAT_EN).
REQ-030 64-bit LOAD 0x0000_0000_FFFF_FFFF, ADD 0x1 -> hi=0x0000_0001, lo=0x0000_0000, ovf=0.
REQ-031 SIMD16 LOAD 0, SUB 0x0000_0001_0000_0000 -> hi=0xFFFF_FFFF, ovf[1]=1, ovf[0]=0 (no macro); hi=0 (macro); then CLEAR -> ovf=0.
REQ-032 in_valid held high with changing prdct during OP_LO/OP_HI -> ignored; result reflects only the accepted prdct.

Source files
------------

// File: rtl/simd_hilo_acc.sv
// SIMD hi/lo accumulator: LOAD/ADD/SUB/CLEAR of a packed 64-bit product, processed as two 32-bit halves.
// Optional macro SIMD_ACC_SAT_EN selects saturating lanes; the default build wraps modulo 2^lane_width.
module simd_hilo_acc #(
  parameter logic [1:0] SIMD8  = 2'b01,
  parameter logic [1:0] SIMD16 = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  simd_sel,
  input  logic [1:0]  op,
  input  logic [63:0] prdct,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic [3:0]  ovf
);

`ifdef SIMD_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OP_LO, OP_HI} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t      state, state_next;
  logic [63:0] acc;
  logic [63:0] cap_prdct;
  logic [1:0]  cap_sel;
  op_t         cap_op;
  logic        carry;

  logic        is_simd8, is_simd16, is_wide, is_sub, cin;
  logic [31:0] half_a, half_b, half_res, lo_next, sat_val;
  logic [16:0] lane0, lane1;
  logic [32:0] word;
  logic [1:0]  half_flg;

  assign in_ready = (state == IDLE);

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = OP_LO;
      OP_LO:   state_next = OP_HI;
      OP_HI:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One 32-bit half per cycle; only the 64-bit lane chains a carry from OP_LO into OP_HI.
  always_comb begin
    is_simd8  = (cap_sel == SIMD8);
    is_simd16 = (cap_sel == SIMD16) && !is_simd8;
    is_wide   = !is_simd8 && !is_simd16;
    is_sub    = (cap_op == OP_SUB);
    half_a    = (state == OP_HI) ? acc[63:32] : acc[31:0];
    half_b    = (state == OP_HI) ? cap_prdct[63:32] : cap_prdct[31:0];
    cin       = (state == OP_HI) && is_wide && carry;
    sat_val   = is_sub ? 32'h0000_0000 : 32'hFFFF_FFFF;

    lane0 = is_sub ? ({1'b0, half_a[15:0]} - {1'b0, half_b[15:0]})
                   : ({1'b0, half_a[15:0]} + {1'b0, half_b[15:0]});
    lane1 = is_sub ? ({1'b0, half_a[31:16]} - {1'b0, half_b[31:16]})
                   : ({1'b0, half_a[31:16]} + {1'b0, half_b[31:16]});
    word  = is_sub ? ({1'b0, half_a} - {1'b0, half_b} - {32'd0, cin})
                   : ({1'b0, half_a} + {1'b0, half_b} + {32'd0, cin});

    half_res = word[31:0];
    half_flg = {1'b0, word[32]};
    lo_next  = acc[31:0];
    if (is_simd8) begin
      half_res = {lane1[15:0], lane0[15:0]};
      half_flg = {lane1[16], lane0[16]};
    end

    if (SAT_EN) begin
      if (is_simd8) begin
        if (lane0[16]) half_res[15:0]  = sat_val[15:0];
        if (lane1[16]) half_res[31:16] = sat_val[31:16];
      end else if (is_simd16) begin
        if (word[32]) half_res = sat_val;
      end else if (state == OP_HI && word[32]) begin
        // A 64-bit overflow is only known in OP_HI, so the low half is clamped retroactively.
        half_res = sat_val;
        lo_next  = sat_val;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cap_prdct <= '0;
      cap_sel   <= '0;
      cap_op    <= OP_LOAD;
      carry     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      ovf       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_prdct <= prdct;
            cap_sel   <= simd_sel;
            cap_op    <= op_t'(op);
          end
        end
        OP_LO: begin
          carry <= 1'b0;
          case (cap_op)
            OP_LOAD:  acc[31:0] <= cap_prdct[31:0];
            OP_CLEAR: begin
              acc[31:0] <= '0;
              ovf       <= '0;
            end
            default: begin
              acc[31:0] <= half_res;
              carry     <= half_flg[0];
              if (is_simd8)       ovf[1:0] <= ovf[1:0] | half_flg;
              else if (is_simd16) ovf[0]   <= ovf[0] | half_flg[0];
            end
          endcase
        end
        OP_HI: begin
          done <= 1'b1;
          case (cap_op)
            OP_LOAD: begin
              acc[63:32] <= cap_prdct[63:32];
              hi         <= cap_prdct[63:32];
              lo         <= acc[31:0];
            end
            OP_CLEAR: begin
              acc[63:32] <= '0;
              hi         <= '0;
              lo         <= acc[31:0];
            end
            default: begin
              acc <= {half_res, lo_next};
              hi  <= half_res;
              lo  <= lo_next;
              if (is_simd8)       ovf[3:2] <= ovf[3:2] | half_flg;
              else if (is_simd16) ovf[1]   <= ovf[1] | half_flg[0];
              else                ovf[0]   <= ovf[0] | half_flg[0];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_hilo_acc.sv
// Directed self-checking bench for simd_hilo_acc; expectations follow SIMD_ACC_SAT_EN when it is defined.
module tb_simd_hilo_acc;

  localparam logic [1:0] S8  = 2'b01;
  localparam logic [1:0] S16 = 2'b10;
  localparam logic [1:0] S64 = 2'b00;
  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLEAR = 2'b11;

`ifdef SIMD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  simd_sel;
  logic [1:0]  op;
  logic [63:0] prdct;
  logic [31:0] hi, lo;
  logic        done;
  logic [3:0]  ovf;

  int n_checks = 0;
  int n_errors = 0;

  simd_hilo_acc dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .simd_sel (simd_sel),
    .op       (op),
    .prdct    (prdct),
    .hi       (hi),
    .lo       (lo),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation from a negedge; returns at the negedge of the done cycle.
  task automatic issue(input logic [1:0] sel, input logic [1:0] code, input logic [63:0] p,
                       input bit noise, input string tag);
    int wait_cnt = 0;
    int lat = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    simd_sel = sel;
    op       = code;
    prdct    = p;
    in_valid = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (noise) begin
        prdct    = {$urandom, $urandom};
        op       = 2'($urandom);
        simd_sel = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end while (!done && lat < 10);
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_ready_in_done"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input logic [1:0] sel, input logic [1:0] code, input logic [63:0] p,
                     input bit noise, input string tag,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic [3:0] exp_ovf);
    issue(sel, code, p, noise, tag);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    simd_sel = '0;
    op       = '0;
    prdct    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // SIMD8 lane-wise add, no overflow
    run(S8, LOAD, 64'h0001_0002_0003_0004, 1'b0, "s8_load", 32'h0001_0002, 32'h0003_0004, 4'b0000);
    @(negedge clk);
    check("s8_done_pulse", 64'(done), 64'd0);
    run(S8, ADD, 64'h0001_0002_0003_0004, 1'b0, "s8_add", 32'h0002_0004, 32'h0006_0008, 4'b0000);

    // SIMD8 lane 0 overflow, no spill into lane 1
    run(S8, LOAD, 64'h0000_0000_0000_FFFF, 1'b0, "s8_ld_ff", 32'h0, 32'h0000_FFFF, 4'b0000);
    run(S8, ADD, 64'h0000_0000_0000_0002, 1'b0, "s8_ovf", 32'h0,
        SAT ? 32'h0000_FFFF : 32'h0000_0001, 4'b0001);
    run(S8, CLEAR, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, "clr1", 32'h0, 32'h0, 4'b0000);

    // 64-bit carry and borrow across halves
    run(S64, LOAD, 64'h0000_0000_FFFF_FFFF, 1'b0, "w_load", 32'h0, 32'hFFFF_FFFF, 4'b0000);
    run(S64, ADD, 64'h1, 1'b0, "w_carry", 32'h0000_0001, 32'h0, 4'b0000);
    run(S64, LOAD, 64'h0000_0001_0000_0000, 1'b0, "w_load2", 32'h1, 32'h0, 4'b0000);
    run(S64, SUB, 64'h1, 1'b0, "w_borrow", 32'h0, 32'hFFFF_FFFF, 4'b0000);

    // SIMD16 upper lane underflow, then CLEAR drops sticky flags
    run(S16, LOAD, 64'h0, 1'b0, "s16_load", 32'h0, 32'h0, 4'b0000);
    run(S16, SUB, 64'h0000_0001_0000_0000, 1'b0, "s16_sub",
        SAT ? 32'h0 : 32'hFFFF_FFFF, 32'h0, 4'b0010);
    run(S16, ADD, 64'h0, 1'b0, "s16_sticky", SAT ? 32'h0 : 32'hFFFF_FFFF, 32'h0, 4'b0010);
    run(S16, CLEAR, 64'h0, 1'b0, "clr2", 32'h0, 32'h0, 4'b0000);

    // Mode change reinterprets acc: lane 0 wraps at 16 bits, not 32
    run(S16, LOAD, 64'h0000_0000_0000_FFFF, 1'b0, "re_load", 32'h0, 32'h0000_FFFF, 4'b0000);
    run(S8, ADD, 64'h1, 1'b0, "re_add", 32'h0, SAT ? 32'h0000_FFFF : 32'h0, 4'b0001);
    run(S8, CLEAR, 64'h0, 1'b0, "clr3", 32'h0, 32'h0, 4'b0000);

    // in_valid held high with changing inputs while busy
    run(S16, LOAD, 64'h0000_0005_0000_0003, 1'b1, "nz_load", 32'h5, 32'h3, 4'b0000);
    run(S16, ADD, 64'h0000_0007_0000_0009, 1'b1, "nz_add", 32'h0000_000C, 32'h0000_000C, 4'b0000);

    // Full 64-bit underflow
    run(2'b11, LOAD, 64'h0, 1'b0, "w_ld0", 32'h0, 32'h0, 4'b0000);
    run(2'b11, SUB, 64'h1, 1'b0, "w_under",
        SAT ? 32'h0 : 32'hFFFF_FFFF, SAT ? 32'h0 : 32'hFFFF_FFFF, 4'b0001);
    run(S8, LOAD, 64'h1111_2222_3333_4444, 1'b0, "pre_rst", 32'h1111_2222, 32'h3333_4444, 4'b0001);

    // Reset during OP_HI aborts the operation
    simd_sel = S8;
    op       = ADD;
    prdct    = 64'h0101_0101_0101_0101;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    run(S64, ADD, 64'h0, 1'b0, "post_rst", 32'h0, 32'h0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
